// File: rtl/latch_mailbox_reader_if.sv
// latch_mailbox_reader_if: writer/reader bus of the command mailbox; master drives the strobes, slave is the mailbox.
interface latch_mailbox_reader_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] wr_data;
  logic              wr_n;
  logic              rd_n;
  logic              st_n;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] st_data;
  logic              irq_n;
  modport master (output wr_data, wr_n, rd_n, st_n, input rd_data, st_data, irq_n);
  modport slave  (input wr_data, wr_n, rd_n, st_n, output rd_data, st_data, irq_n);
endinterface

// File: rtl/latch_mailbox_reader.sv
// latch_mailbox_reader: reader side of a CPU-to-CPU command latch with pending/overrun/hold status and irq_n; ports clk, reset, bus (slave: wr_data/wr_n in, rd_n/st_n in, rd_data/st_data/irq_n out); define LATCH_MAILBOX_SYNC_EN to add 2-flop strobe synchronisers.
module latch_mailbox_reader #(
  parameter int              DATA_W   = 8,
  parameter logic [DATA_W-1:0] OPEN_BUS = '1
) (
  input logic clk,
  input logic reset,
  latch_mailbox_reader_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FULL, READING} state_t;
  state_t            state_q;
  logic [2:0]        strb;
  logic              wr_q, rd_q, st_q;
  logic [DATA_W-1:0] data_q, hold_q;
  logic              pending_q, overrun_q, held_q, irq_n_q;
  logic              wr_rise, rd_rise, rd_fall, st_rise, ov_set;
`ifdef LATCH_MAILBOX_SYNC_EN
  logic [2:0] s1_q, s2_q;
  always_ff @(posedge clk)
    if (reset) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= {bus.wr_n, bus.rd_n, bus.st_n};
      s2_q <= s1_q;
    end
  assign strb = s2_q;
`else
  assign strb = {bus.wr_n, bus.rd_n, bus.st_n};
`endif
  assign wr_rise = ~wr_q & strb[2];
  assign rd_rise = ~rd_q & strb[1];
  assign rd_fall = rd_q & ~strb[1];
  assign st_rise = ~st_q & strb[0];
  // a write while FULL, or while READING with the hold slot occupied, loses a byte
  assign ov_set  = wr_rise & (state_q == FULL || (state_q == READING && held_q));
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= EMPTY;
      {wr_q, rd_q, st_q} <= '1;
      data_q    <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      held_q    <= 1'b0;
      irq_n_q   <= 1'b1;
    end else begin
      {wr_q, rd_q, st_q} <= strb;
      irq_n_q   <= ~pending_q;
      overrun_q <= ov_set | (overrun_q & ~st_rise);
      case (state_q)
        EMPTY:
          if (wr_rise) begin
            data_q    <= bus.wr_data;
            pending_q <= 1'b1;
            state_q   <= FULL;
          end
        FULL: begin
          if (wr_rise) data_q <= bus.wr_data;
          if (rd_fall) state_q <= READING;
        end
        READING:
          if (rd_rise) begin
            held_q  <= 1'b0;
            state_q <= FULL;
            if (wr_rise) data_q <= bus.wr_data;
            else if (held_q) data_q <= hold_q;
            else begin
              pending_q <= 1'b0;
              state_q   <= EMPTY;
            end
          end else if (wr_rise) begin
            hold_q <= bus.wr_data;
            held_q <= 1'b1;
          end
        default: state_q <= EMPTY;
      endcase
    end
  assign bus.rd_data = bus.rd_n ? OPEN_BUS : data_q;
  assign bus.st_data = bus.st_n ? OPEN_BUS : {pending_q, overrun_q, held_q, {(DATA_W-3){1'b0}}};
  assign bus.irq_n   = irq_n_q;
endmodule

// File: tb/tb_latch_mailbox_reader.sv
// tb_latch_mailbox_reader: directed and randomized check of the mailbox against a flag-level reference model.
module tb_latch_mailbox_reader;
`ifdef LATCH_MAILBOX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  latch_mailbox_reader_if #(.DATA_W(8)) bus ();
  latch_mailbox_reader #(.DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] m_data, m_hold;
  bit m_pend, m_ov, m_held, m_reading, m_irq;
  bit pw, pr, ps;
  bit [2:0] p1, p2;
  always @(posedge clk) begin
    bit [2:0] raw, cur;
    bit wr_r, rd_r, rd_f, st_r, ov_set;
    raw = {bus.wr_n, bus.rd_n, bus.st_n};
    if (reset) begin
      m_data = 0; m_hold = 0; m_pend = 0; m_ov = 0; m_held = 0; m_reading = 0; m_irq = 1;
      pw = 1; pr = 1; ps = 1; p1 = 3'b111; p2 = 3'b111;
    end else begin
      cur = (LAT == 2) ? p2 : raw;
      p2 = p1; p1 = raw;
      wr_r = !pw && cur[2]; rd_r = !pr && cur[1]; rd_f = pr && !cur[1]; st_r = !ps && cur[0];
      {pw, pr, ps} = cur;
      ov_set = 0;
      m_irq = !m_pend;
      if (!m_pend) begin
        if (wr_r) begin m_data = bus.wr_data; m_pend = 1; end
      end else if (!m_reading) begin
        if (wr_r) begin m_data = bus.wr_data; ov_set = 1; end
        if (rd_f) m_reading = 1;
      end else if (rd_r) begin
        m_reading = 0;
        if (wr_r) begin m_data = bus.wr_data; ov_set = m_held; end
        else if (m_held) m_data = m_hold;
        else m_pend = 0;
        m_held = 0;
      end else if (wr_r) begin
        ov_set = m_held; m_hold = bus.wr_data; m_held = 1;
      end
      m_ov = ov_set ? 1'b1 : (st_r ? 1'b0 : m_ov);
    end
  end
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("model_rd_data", bus.rd_data, bus.rd_n ? 8'hFF : m_data);
      chk("model_st_data", bus.st_data, bus.st_n ? 8'hFF : {m_pend, m_ov, m_held, 5'b0});
      chk("model_irq_n", {7'b0, bus.irq_n}, {7'b0, m_irq});
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] d);
    bus.wr_data = d; bus.wr_n = 1'b0;
    cyc(1);
    bus.wr_n = 1'b1;
    cyc(6);
  endtask
  task automatic st_look(input string nm, input logic [7:0] exp);
    bus.st_n = 1'b0; #1;
    chk(nm, bus.st_data, exp);
    cyc(1);
    bus.st_n = 1'b1;
    cyc(6);
  endtask
  initial begin
    int since;
    bus.wr_data = 8'h00; bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.st_n = 1'b1;
    cyc(3);
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_irq_n", {7'b0, bus.irq_n}, 8'h01);
    chk("idle_rd_data", bus.rd_data, 8'hFF);
    chk("idle_st_data", bus.st_data, 8'hFF);
    cyc(1);
    st_look("rst_status", 8'h00);
    bus.wr_data = 8'h5A; bus.wr_n = 1'b0;
    cyc(1);
    bus.wr_n = 1'b1;
    repeat (1 + LAT) @(posedge clk);
    #1 chk("irq_n_before", {7'b0, bus.irq_n}, 8'h01);
    @(posedge clk);
    #1 chk("irq_n_fall", {7'b0, bus.irq_n}, 8'h00);
    cyc(4);
    bus.rd_n = 1'b0; #1;
    chk("t1_rd_data", bus.rd_data, 8'h5A);
    cyc(4);
    bus.rd_n = 1'b1;
    cyc(6);
    chk("t1_irq_n_rise", {7'b0, bus.irq_n}, 8'h01);
    wr(8'h11); wr(8'h22);
    st_look("t2_status_ov", 8'hC0);
    st_look("t2_status_clr", 8'h80);
    bus.rd_n = 1'b0; #1;
    chk("t2_rd_data", bus.rd_data, 8'h22);
    cyc(4);
    bus.rd_n = 1'b1;
    cyc(6);
    wr(8'h33);
    bus.rd_n = 1'b0;
    cyc(6);
    wr(8'h44);
    chk("t3_frozen", bus.rd_data, 8'h33);
    st_look("t3_status_held", 8'hA0);
    bus.rd_n = 1'b1;
    cyc(6);
    chk("t3_irq_n", {7'b0, bus.irq_n}, 8'h00);
    bus.rd_n = 1'b0; #1;
    chk("t3_rd_hold", bus.rd_data, 8'h44);
    cyc(6);
    bus.rd_n = 1'b1;
    cyc(6);
    wr(8'h55);
    bus.rd_n = 1'b0;
    cyc(6);
    bus.wr_data = 8'h66; bus.wr_n = 1'b0;
    cyc(1);
    bus.wr_n = 1'b1; bus.rd_n = 1'b1;
    cyc(6);
    st_look("t4_status", 8'h80);
    bus.rd_n = 1'b0; #1;
    chk("t4_rd_data", bus.rd_data, 8'h66);
    cyc(6);
    bus.rd_n = 1'b1;
    cyc(6);
    wr(8'h77);
    bus.rd_n = 1'b0;
    cyc(6);
    wr(8'h88);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; #1;
    chk("t5_irq_n", {7'b0, bus.irq_n}, 8'h01);
    chk("t5_rd_data", bus.rd_data, 8'h00);
    cyc(1);
    st_look("t5_status", 8'h00);
    bus.rd_n = 1'b1;
    cyc(6);
    st_look("t5_rd_ignored", 8'h00);
    chk("t6_rd_open", bus.rd_data, 8'hFF);
    chk("t6_st_open", bus.st_data, 8'hFF);
    since = 10;
    for (int i = 0; i < 4000; i++) begin
      cyc(1);
      reset = ($urandom_range(0, 399) == 0);
      since++;
      if (bus.wr_n && since >= 5 && $urandom_range(0, 3) == 0) begin
        bus.wr_n = 1'b0; bus.wr_data = 8'($urandom);
      end else if (!bus.wr_n && $urandom_range(0, 1) == 0) begin
        bus.wr_n = 1'b1; since = 0;
      end
      if ($urandom_range(0, 4) == 0) bus.rd_n = ~bus.rd_n;
      if ($urandom_range(0, 5) == 0) bus.st_n = ~bus.st_n;
    end
    reset = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
